// File: rtl/silencer_sequencer.sv
// Sweep sequencer for the silencer interpolator: streams DEPTH source reads, counts returned samples, pulses DONE.
// Optional watchdog abort is compiled in with `define SILENCER_SEQ_WDT_EN.
module silencer_sequencer #(
    parameter int DEPTH      = 249,
    parameter int WDT_MARGIN = 16
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     UPDATE,
    input  logic                     CFG_VALID,
    input  logic [15:0]              CFG_RATE_INTENSITY,
    input  logic [15:0]              CFG_RATE_PHASE,
    output logic                     DIN_VALID,
    output logic [15:0]              UPDATE_RATE_INTENSITY,
    output logic [15:0]              UPDATE_RATE_PHASE,
    output logic                     SRC_EN,
    output logic [$clog2(DEPTH)-1:0] SRC_ADDR,
    input  logic                     DOUT_VALID,
    output logic                     BUSY,
    output logic                     DONE,
    output logic [15:0]              OVERRUN_CNT,
    output logic                     ERR
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;

    logic [1:0]    r_state;
    logic [15:0]   r_pend_int;
    logic [15:0]   r_pend_ph;
    logic [15:0]   r_act_int;
    logic [15:0]   r_act_ph;
    logic          r_din_valid;
    logic          r_src_en;
    logic [AW-1:0] r_src_addr;
    logic [AW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;
    logic [15:0]   r_overrun;

    logic [15:0]   w_cfg_int;
    logic [15:0]   w_cfg_ph;
    logic          w_start;
    logic          w_overrun;
    logic          w_last_sample;
    logic          w_last_addr;
    logic          w_timeout;

    // A zero rate would stall the interpolator, so it is stored as 1.
    assign w_cfg_int = (CFG_RATE_INTENSITY == 16'd0) ? 16'd1 : CFG_RATE_INTENSITY;
    assign w_cfg_ph  = (CFG_RATE_PHASE == 16'd0) ? 16'd1 : CFG_RATE_PHASE;

    // The DONE cycle is already IDLE, but an UPDATE landing on it is treated as an overrun.
    assign w_start       = UPDATE && (r_state == S_IDLE) && !r_done;
    assign w_overrun     = UPDATE && !w_start;
    assign w_last_sample = DOUT_VALID && (r_state != S_IDLE) && (r_cnt == AW'(DEPTH - 1));
    assign w_last_addr   = (r_src_addr == AW'(DEPTH - 1));

`ifdef SILENCER_SEQ_WDT_EN
    localparam int WDT_LIMIT = DEPTH + WDT_MARGIN + 8;
    localparam int WW        = $clog2(WDT_LIMIT);

    logic [WW-1:0] r_wdt;
    logic          r_err;

    assign w_timeout = (r_state != S_IDLE) && (r_wdt == WW'(WDT_LIMIT - 1)) && !w_last_sample;
    assign ERR       = r_err;

    // Counter is 0 in the DIN_VALID cycle, so the abort lands WDT_LIMIT cycles after it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wdt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_start)
                r_wdt <= '0;
            else if (r_state != S_IDLE)
                r_wdt <= r_wdt + WW'(1);
            if (w_timeout)
                r_err <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign ERR       = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= S_IDLE;
            r_pend_int  <= 16'd1;
            r_pend_ph   <= 16'd1;
            r_act_int   <= 16'd1;
            r_act_ph    <= 16'd1;
            r_din_valid <= 1'b0;
            r_src_en    <= 1'b0;
            r_src_addr  <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 16'd0;
        end else begin
            r_din_valid <= w_start;
            r_done      <= 1'b0;
            if (CFG_VALID) begin
                r_pend_int <= w_cfg_int;
                r_pend_ph  <= w_cfg_ph;
            end
            if (w_overrun && (r_overrun != 16'hFFFF))
                r_overrun <= r_overrun + 16'd1;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_act_int  <= CFG_VALID ? w_cfg_int : r_pend_int;
                        r_act_ph   <= CFG_VALID ? w_cfg_ph : r_pend_ph;
                        r_state    <= S_STREAM;
                        r_busy     <= 1'b1;
                        r_src_en   <= 1'b1;
                        r_src_addr <= '0;
                        r_cnt      <= '0;
                    end
                end
                S_STREAM, S_DRAIN: begin
                    if (w_last_sample || w_timeout) begin
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                        r_done     <= w_last_sample;
                        r_src_en   <= 1'b0;
                        r_src_addr <= '0;
                        r_cnt      <= '0;
                    end else begin
                        if (DOUT_VALID)
                            r_cnt <= r_cnt + AW'(1);
                        if (r_state == S_STREAM) begin
                            if (w_last_addr) begin
                                r_state    <= S_DRAIN;
                                r_src_en   <= 1'b0;
                                r_src_addr <= '0;
                            end else begin
                                r_src_addr <= r_src_addr + AW'(1);
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign DIN_VALID             = r_din_valid;
    assign UPDATE_RATE_INTENSITY = r_act_int;
    assign UPDATE_RATE_PHASE     = r_act_ph;
    assign SRC_EN                = r_src_en;
    assign SRC_ADDR              = r_src_addr;
    assign BUSY                  = r_busy;
    assign DONE                  = r_done;
    assign OVERRUN_CNT           = r_overrun;
endmodule

// File: tb/tb_silencer_sequencer.sv
// Directed bench for silencer_sequencer with an 8-cycle-latency interpolator model.
// Cycle n of a sweep is counted from the UPDATE cycle (n=0); inputs change 1ns after posedge, outputs sampled on negedge.
module tb_silencer_sequencer;
    logic        clk;
    logic        rst_n;
    logic        update;
    logic        cfg_valid;
    logic [15:0] cfg_int;
    logic [15:0] cfg_ph;
    logic        din_valid;
    logic [15:0] rate_int;
    logic [15:0] rate_ph;
    logic        src_en;
    logic [7:0]  src_addr;
    logic        dout_valid;
    logic        busy;
    logic        done;
    logic [15:0] overrun_cnt;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;

    silencer_sequencer #(.DEPTH(249), .WDT_MARGIN(16)) dut (
        .CLK(clk),
        .RST_N(rst_n),
        .UPDATE(update),
        .CFG_VALID(cfg_valid),
        .CFG_RATE_INTENSITY(cfg_int),
        .CFG_RATE_PHASE(cfg_ph),
        .DIN_VALID(din_valid),
        .UPDATE_RATE_INTENSITY(rate_int),
        .UPDATE_RATE_PHASE(rate_ph),
        .SRC_EN(src_en),
        .SRC_ADDR(src_addr),
        .DOUT_VALID(dout_valid),
        .BUSY(busy),
        .DONE(done),
        .OVERRUN_CNT(overrun_cnt),
        .ERR(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Interpolator model: each SRC_EN read returns a sample 8 cycles later, up to 'limit' per sweep.
    logic [7:0] pipe;
    int         sent;
    int         limit;
    logic       extra_dv;

    assign dout_valid = (pipe[7] && (sent < limit)) || extra_dv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= 8'd0;
            sent <= 0;
        end else begin
            pipe <= {pipe[6:0], src_en};
            if (din_valid)
                sent <= 0;
            else if (pipe[7] && (sent < limit))
                sent <= sent + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        update    = 1'b0;
        cfg_valid = 1'b0;
        extra_dv  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_din_valid"}, din_valid, 0);
        check({tag, "_src_en"}, src_en, 0);
        check({tag, "_src_addr"}, src_addr, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_overrun"}, overrun_cnt, 0);
        check({tag, "_rate_int"}, rate_int, 16'h0001);
        check({tag, "_rate_ph"}, rate_ph, 16'h0001);
    endtask

    int e_addr, e_din, e_busy, e_done, e_rate, done_cnt, done_at, err_at;

    initial begin
        rst_n     = 1'b0;
        update    = 1'b0;
        cfg_valid = 1'b0;
        cfg_int   = 16'h0000;
        cfg_ph    = 16'h0000;
        extra_dv  = 1'b0;
        limit     = 249;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        next_cycle();
        next_cycle();

        // Sweep A: rates 0x0100/0x0200, three mid-sweep UPDATEs, one on DONE, CFG write mid-sweep
        next_cycle();
        cfg_valid = 1'b1;
        cfg_int   = 16'h0100;
        cfg_ph    = 16'h0200;
        next_cycle();
        update = 1'b1;
        e_addr = 0; e_din = 0; e_busy = 0; e_done = 0; e_rate = 0;
        for (int n = 1; n <= 262; n++) begin
            next_cycle();
            if (n == 50 || n == 100 || n == 150 || n == 258)
                update = 1'b1;
            if (n == 120) begin
                cfg_valid = 1'b1;
                cfg_int   = 16'h0000;
                cfg_ph    = 16'h0333;
            end
            @(negedge clk);
            if (src_en !== (n <= 249)) e_addr++;
            if (n <= 249 && src_addr !== 8'(n - 1)) e_addr++;
            if (din_valid !== (n == 1)) e_din++;
            if (busy !== (n <= 257)) e_busy++;
            if (done !== (n == 258)) e_done++;
            if (rate_int !== 16'h0100 || rate_ph !== 16'h0200) e_rate++;
        end
        check("a_src_addr_seq", e_addr, 0);
        check("a_din_valid_once", e_din, 0);
        check("a_busy_window", e_busy, 0);
        check("a_done_at_258", e_done, 0);
        check("a_rates_held", e_rate, 0);
        check("a_overrun_cnt", overrun_cnt, 4);
        check("a_err", err, 0);

        // Sweep B: zero rate stored as 1, mid-sweep CFG applied now; reset at SRC_ADDR=100
        next_cycle();
        update = 1'b1;
        for (int n = 1; n <= 101; n++) begin
            next_cycle();
            @(negedge clk);
            if (n == 1) begin
                check("b_din_valid", din_valid, 1);
                check("b_rate_int_zero_to_one", rate_int, 16'h0001);
                check("b_rate_ph", rate_ph, 16'h0333);
            end
        end
        check("b_src_addr_100", src_addr, 100);
        check("b_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            next_cycle();
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        check("b_no_done_after_reset", done_cnt, 0);

        // Sweep C: DOUT_VALID in IDLE ignored, clean restart after reset
        next_cycle();
        extra_dv = 1'b1;
        next_cycle();
        extra_dv = 1'b1;
        next_cycle();
        extra_dv = 1'b1;
        next_cycle();
        update = 1'b1;
        e_addr = 0; done_cnt = 0; done_at = 0;
        for (int n = 1; n <= 262; n++) begin
            next_cycle();
            @(negedge clk);
            if (n <= 249 && (src_en !== 1'b1 || src_addr !== 8'(n - 1))) e_addr++;
            if (done === 1'b1) begin
                done_cnt++;
                done_at = n;
            end
            if (n == 1) begin
                check("c_din_valid", din_valid, 1);
                check("c_rate_int_reset", rate_int, 16'h0001);
                check("c_rate_ph_reset", rate_ph, 16'h0001);
            end
            if (n == 258) check("c_busy_low_with_done", busy, 0);
        end
        check("c_src_addr_restart", e_addr, 0);
        check("c_done_once", done_cnt, 1);
        check("c_done_cycle", done_at, 258);
        check("c_overrun_zero", overrun_cnt, 0);

`ifdef SILENCER_SEQ_WDT_EN
        // Watchdog: model stops at 200 samples, abort 273 cycles after DIN_VALID
        limit = 200;
        next_cycle();
        update = 1'b1;
        done_cnt = 0;
        err_at = 0;
        for (int n = 1; n <= 400 && err_at == 0; n++) begin
            next_cycle();
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (err === 1'b1) err_at = n;
        end
        check("w_err_cycle", err_at, 274);
        check("w_no_done", done_cnt, 0);
        check("w_busy_low", busy, 0);
        limit = 249;
        next_cycle();
        update = 1'b1;
        next_cycle();
        @(negedge clk);
        check("w_next_update_accepted", din_valid, 1);
        check("w_err_sticky", err, 1);
`else
        check("err_tied_low", err, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
